// File: rtl/rx_depckg_pkg.sv
// Purpose: shared constants, header/trailer field positions and FSM encoding for the receive depacketiser.
// Latency: n/a (definitions only).
// Backpressure: n/a; the link has no flow control.
package rx_depckg_pkg;

  localparam int WORD_W  = 24;
  localparam int DATA_W  = 8;
  localparam int LEN_MAX = 63;
  localparam int LEN_W   = $clog2(LEN_MAX + 1);

  localparam logic [DATA_W-1:0] SYNC_HDR = 8'hA5;
  localparam logic [DATA_W-1:0] SYNC_TRL = 8'h5A;

  // Field positions, shared by header and trailer words.
  localparam int SYNC_HI = 23;
  localparam int SYNC_LO = 16;
  localparam int CH_HI   = 15;
  localparam int CH_LO   = 14;
  localparam int LEN_HI  = 13;
  localparam int LEN_LO  = 8;
  localparam int SUM_HI  = 15;
  localparam int SUM_LO  = 8;
  localparam int SEQ_HI  = 7;
  localparam int SEQ_LO  = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_TRAILER = 2'd2
  } state_t;

  // One-hot FIFO strobe {ch3, ch2, ch1}; channel 0 selects nothing.
  function automatic logic [2:0] ch_strobe(input logic [1:0] ch);
    return {ch == 2'd3, ch == 2'd2, ch == 2'd1};
  endfunction

endpackage

// File: rtl/rx_byte_unpack.sv
// Purpose: splits a payload word into three bytes on the selected channel strobe and keeps the running checksum.
// Latency: bytes appear 1, 2 and 3 cycles after load; data_out and strobes are registered.
// Backpressure: none; a new word or flush while unpacking drops the leftover bytes (their sum is kept).
// Ports: load/word/ch start a word; flush aborts unpacking; clr_sum zeroes the sum (with flush);
//        wr_en_ch1..3 + data_out drive the FIFOs; sum_final includes bytes not yet emitted; active = bytes pending.
module rx_byte_unpack
  import rx_depckg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic              clr_sum,
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        ch,
  output logic              wr_en_ch1,
  output logic              wr_en_ch2,
  output logic              wr_en_ch3,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] sum_final,
  output logic              active
);

  logic [WORD_W-1:0] sr;
  logic [1:0]        cnt;   // bytes of the current word not yet retired, incl. the one on data_out
  logic [1:0]        wch;
  logic [DATA_W-1:0] sum;   // sum of bytes already placed on data_out
  logic [2:0]        stb;

  // Bytes still waiting in the shift register are folded in so a trailer
  // arriving early compares against the whole word.
  always_comb begin
    sum_final = sum;
    if (cnt == 2'd3)
      sum_final = sum + sr[WORD_W-1 -: DATA_W] + sr[WORD_W-DATA_W-1 -: DATA_W];
    else if (cnt == 2'd2)
      sum_final = sum + sr[WORD_W-1 -: DATA_W];
  end

  assign active = (cnt != 2'd0);
  assign {wr_en_ch3, wr_en_ch2, wr_en_ch1} = stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      cnt      <= 2'd0;
      wch      <= 2'd0;
      sum      <= '0;
      stb      <= 3'b000;
      data_out <= '0;
    end else if (load) begin
      // First byte goes out immediately; the remaining two shift up behind it.
      sr       <= {word[WORD_W-DATA_W-1:0], {DATA_W{1'b0}}};
      cnt      <= 2'd3;
      wch      <= ch;
      stb      <= ch_strobe(ch);
      data_out <= word[WORD_W-1 -: DATA_W];
      sum      <= sum_final + word[WORD_W-1 -: DATA_W];
    end else if (flush) begin
      cnt <= 2'd0;
      stb <= 3'b000;
      sum <= clr_sum ? '0 : sum_final;
    end else if (cnt > 2'd1) begin
      sr       <= {sr[WORD_W-DATA_W-1:0], {DATA_W{1'b0}}};
      cnt      <= cnt - 2'd1;
      stb      <= ch_strobe(wch);
      data_out <= sr[WORD_W-1 -: DATA_W];
      sum      <= sum + sr[WORD_W-1 -: DATA_W];
    end else if (cnt == 2'd1) begin
      cnt <= 2'd0;
      stb <= 3'b000;
    end
  end

endmodule

// File: rtl/rx_depckg.sv
// Purpose: receive-side packet parser; checks sync, checksum and per-channel sequence, demuxes payload bytes.
// Latency: status pulses and first payload byte 1 cycle after rx_ena; bytes at +1/+2/+3.
// Backpressure: none; words closer than 3 cycles in payload raise ovr_err and drop leftover bytes.
// Ports: rx_data/rx_ena from the LVDS receiver; wr_en_ch1..3 + data_out to the receive FIFOs;
//        pkt_ok/pkt_err/hdr_err/seq_err/ovr_err one-cycle status pulses; busy = not IDLE.
module rx_depckg
  import rx_depckg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] rx_data,
  input  logic              rx_ena,
  output logic              wr_en_ch1,
  output logic              wr_en_ch2,
  output logic              wr_en_ch3,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_ok,
  output logic              pkt_err,
  output logic              hdr_err,
  output logic              seq_err,
  output logic              ovr_err,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [1:0]        ch_q, ch_nxt;
  logic [LEN_W-1:0]  rem_q, rem_nxt;
  logic [DATA_W-1:0] exp_seq1, exp_seq2, exp_seq3, exp_cur;
  logic              pkt_ok_nxt, pkt_err_nxt, hdr_err_nxt, seq_err_nxt, ovr_err_nxt;
  logic              seq_wr, load, clr_sum, active;
  logic [DATA_W-1:0] sum_final;

  logic [DATA_W-1:0] f_sync, f_sum, f_seq;
  logic [1:0]        f_ch;
  logic [LEN_W-1:0]  f_len;

  assign f_sync = rx_data[SYNC_HI:SYNC_LO];
  assign f_ch   = rx_data[CH_HI:CH_LO];
  assign f_len  = rx_data[LEN_HI:LEN_LO];
  assign f_sum  = rx_data[SUM_HI:SUM_LO];
  assign f_seq  = rx_data[SEQ_HI:SEQ_LO];

  assign busy = (state != S_IDLE);

  always_comb begin
    case (ch_q)
      2'd1:    exp_cur = exp_seq1;
      2'd2:    exp_cur = exp_seq2;
      2'd3:    exp_cur = exp_seq3;
      default: exp_cur = '0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch_q;
    rem_nxt     = rem_q;
    pkt_ok_nxt  = 1'b0;
    pkt_err_nxt = 1'b0;
    hdr_err_nxt = 1'b0;
    seq_err_nxt = 1'b0;
    seq_wr      = 1'b0;
    load        = 1'b0;
    clr_sum     = 1'b0;
    ovr_err_nxt = rx_ena && active;
    if (rx_ena) begin
      case (state)
        S_IDLE: begin
          if (f_sync == SYNC_HDR && f_ch != 2'd0 && f_len != '0) begin
            ch_nxt    = f_ch;
            rem_nxt   = f_len;
            clr_sum   = 1'b1;
            state_nxt = S_PAYLOAD;
          end else begin
            hdr_err_nxt = 1'b1;
          end
        end
        S_PAYLOAD: begin
          load    = 1'b1;
          rem_nxt = rem_q - 1'b1;
          if (rem_q == 1) state_nxt = S_TRAILER;
        end
        S_TRAILER: begin
          if (f_sync == SYNC_TRL && f_sum == sum_final) begin
            pkt_ok_nxt  = 1'b1;
            seq_wr      = 1'b1;
            seq_err_nxt = (f_seq != exp_cur);
          end else begin
            pkt_err_nxt = 1'b1;
          end
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ch_q     <= 2'd0;
      rem_q    <= '0;
      exp_seq1 <= '0;
      exp_seq2 <= '0;
      exp_seq3 <= '0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      hdr_err  <= 1'b0;
      seq_err  <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch_q    <= ch_nxt;
      rem_q   <= rem_nxt;
      pkt_ok  <= pkt_ok_nxt;
      pkt_err <= pkt_err_nxt;
      hdr_err <= hdr_err_nxt;
      seq_err <= seq_err_nxt;
      ovr_err <= ovr_err_nxt;
      // Resynchronise to the received sequence whether or not it matched.
      if (seq_wr) begin
        case (ch_q)
          2'd1:    exp_seq1 <= f_seq + 1'b1;
          2'd2:    exp_seq2 <= f_seq + 1'b1;
          2'd3:    exp_seq3 <= f_seq + 1'b1;
          default: ;
        endcase
      end
    end
  end

  rx_byte_unpack u_unpack (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .flush     (rx_ena && !load),
    .clr_sum   (clr_sum),
    .word      (rx_data),
    .ch        (ch_nxt),
    .wr_en_ch1 (wr_en_ch1),
    .wr_en_ch2 (wr_en_ch2),
    .wr_en_ch3 (wr_en_ch3),
    .data_out  (data_out),
    .sum_final (sum_final),
    .active    (active)
  );

endmodule

// File: tb/tb_rx_depckg.sv
// Purpose: directed self-checking bench for rx_depckg.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_rx_depckg;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rx_data;
  logic        rx_ena;
  logic        wr_en_ch1, wr_en_ch2, wr_en_ch3;
  logic [7:0]  data_out;
  logic        pkt_ok, pkt_err, hdr_err, seq_err, ovr_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Event counters, written only by the monitor.
  int c1 = 0, c2 = 0, c3 = 0, c_ok = 0, c_perr = 0, c_herr = 0, c_serr = 0, c_ovr = 0, c_multi = 0;
  logic [7:0] q[$];

  // Snapshots, written only by the stimulus block.
  int b1, b2, b3, b_ok, b_perr, b_herr, b_serr, b_ovr;

  always #12.5 clk = ~clk;

  rx_depckg dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_ena    (rx_ena),
    .wr_en_ch1 (wr_en_ch1),
    .wr_en_ch2 (wr_en_ch2),
    .wr_en_ch3 (wr_en_ch3),
    .data_out  (data_out),
    .pkt_ok    (pkt_ok),
    .pkt_err   (pkt_err),
    .hdr_err   (hdr_err),
    .seq_err   (seq_err),
    .ovr_err   (ovr_err),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_ch1) c1++;
      if (wr_en_ch2) c2++;
      if (wr_en_ch3) c3++;
      if (wr_en_ch1 || wr_en_ch2 || wr_en_ch3) q.push_back(data_out);
      if (int'(wr_en_ch1) + int'(wr_en_ch2) + int'(wr_en_ch3) > 1) c_multi++;
      if ((int'(pkt_ok) + int'(pkt_err) + int'(hdr_err)) > 1) c_multi++;
      if (pkt_ok)  c_ok++;
      if (pkt_err) c_perr++;
      if (hdr_err) c_herr++;
      if (seq_err) c_serr++;
      if (ovr_err) c_ovr++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b1 = c1; b2 = c2; b3 = c3; b_ok = c_ok; b_perr = c_perr;
    b_herr = c_herr; b_serr = c_serr; b_ovr = c_ovr;
  endtask

  function automatic logic [63:0] last_bytes(input int n);
    logic [63:0] r = '0;
    if (q.size() < n) return 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < n; i++) r = {r[55:0], q[q.size() - n + i]};
    return r;
  endfunction

  // One word with normal spacing; returns #1 after a falling edge.
  task automatic send(input logic [23:0] w);
    @(negedge clk);
    rx_data = w;
    rx_ena  = 1'b1;
    @(negedge clk);
    rx_ena  = 1'b0;
    repeat (6) @(negedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    rx_ena  = 1'b0;
    rx_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          {wr_en_ch1, wr_en_ch2, wr_en_ch3, data_out, pkt_ok, pkt_err, hdr_err, seq_err, ovr_err, busy}, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: good single packet, ch1 len1
    snap();
    send(24'hA54100);
    check("t1_busy_after_hdr", busy, 1);
    send(24'h112233);
    send(24'h5A6600);
    check("t1_ch1_writes", c1 - b1, 3);
    check("t1_bytes", last_bytes(3), 64'h112233);
    check("t1_pkt_ok", c_ok - b_ok, 1);
    check("t1_seq_err", c_serr - b_serr, 0);
    check("t1_busy_idle", busy, 0);

    // 2: ch3 len2 demux
    snap();
    send(24'hA5C200);
    send(24'h010203);
    send(24'h040506);
    send(24'h5A1500);
    check("t2_ch3_writes", c3 - b3, 6);
    check("t2_other_writes", (c1 - b1) + (c2 - b2), 0);
    check("t2_bytes", last_bytes(6), 64'h010203040506);
    check("t2_pkt_ok", c_ok - b_ok, 1);

    // 3: checksum failure, then next header accepted
    snap();
    send(24'hA54100);
    send(24'h112233);
    send(24'h5A6700);
    check("t3_ch1_writes", c1 - b1, 3);
    check("t3_pkt_err", c_perr - b_perr, 1);
    check("t3_no_pkt_ok", c_ok - b_ok, 0);
    send(24'hA54100);
    check("t3_next_hdr_busy", busy, 1);
    check("t3_next_hdr_no_err", c_herr - b_herr, 0);
    send(24'h112233);
    send(24'h5A6601);  // bad-checksum packet left exp_seq1 at 1
    check("t3_recover_ok", c_ok - b_ok, 1);
    check("t3_recover_seq", c_serr - b_serr, 0);

    // 4: rejected headers
    snap();
    send(24'h000000);
    check("t4_busy_a", busy, 0);
    send(24'hA50100);
    check("t4_busy_b", busy, 0);
    check("t4_hdr_err", c_herr - b_herr, 2);
    check("t4_no_writes", (c1 - b1) + (c2 - b2) + (c3 - b3), 0);

    // 5: ch2 sequence gap (AA+BB+CC = 0x231 -> 0x31)
    snap();
    send(24'hA58100); send(24'hAABBCC); send(24'h5A3100);
    check("t5_first_seq", c_serr - b_serr, 0);
    send(24'hA58100); send(24'hAABBCC); send(24'h5A3102);
    check("t5_gap_ok", c_ok - b_ok, 2);
    check("t5_gap_seq_err", c_serr - b_serr, 1);
    send(24'hA58100); send(24'hAABBCC); send(24'h5A3103);
    check("t5_resync_ok", c_ok - b_ok, 3);
    check("t5_resync_seq", c_serr - b_serr, 1);
    check("t5_ch2_writes", c2 - b2, 9);

    // 6a: reset mid-packet discards it silently; exp_seq1 returns to 0
    send(24'hA54300);
    send(24'h112233);
    snap();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("t6_reset_outputs",
          {wr_en_ch1, wr_en_ch2, wr_en_ch3, data_out, pkt_ok, pkt_err, hdr_err, seq_err, ovr_err, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    send(24'hA54100);
    send(24'h112233);
    send(24'h5A6600);
    check("t6_after_reset_ok", c_ok - b_ok, 1);
    check("t6_after_reset_seq", c_serr - b_serr, 0);
    check("t6_no_err_pulse", (c_perr - b_perr) + (c_herr - b_herr), 0);
    check("t6_ch1_writes", c1 - b1, 3);
    check("no_ovr_normal_spacing", c_ovr, 0);

    // 6b: overrun, words one cycle apart; 01 then 02 02 02 emitted, sum covers all six
    snap();
    send(24'hA54200);
    @(negedge clk);
    rx_data = 24'h010101;
    rx_ena  = 1'b1;
    @(negedge clk);
    rx_data = 24'h020202;
    @(negedge clk);
    rx_ena  = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("t6_ovr_err", c_ovr - b_ovr, 1);
    check("t6_ovr_writes", c1 - b1, 4);
    check("t6_ovr_bytes", last_bytes(4), 64'h01020202);
    send(24'h5A0901);
    check("t6_ovr_pkt_ok", c_ok - b_ok, 1);
    check("t6_ovr_seq", c_serr - b_serr, 0);

    check("exclusive_pulses", c_multi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
